// File: rtl/midi_msg_parser_pkg.sv
// Shared MIDI definitions for the message parser: status constants, parser
// state encodings and the per-status data length lookup.
package midi_msg_parser_pkg;

  // Message type codes, equal to status[6:4] of a channel-voice status byte
  localparam logic [2:0] MIDI_NOTE_OFF   = 3'd0;
  localparam logic [2:0] MIDI_NOTE_ON    = 3'd1;
  localparam logic [2:0] MIDI_POLY_AT    = 3'd2;
  localparam logic [2:0] MIDI_CC         = 3'd3;
  localparam logic [2:0] MIDI_PROG       = 3'd4;
  localparam logic [2:0] MIDI_CHAN_AT    = 3'd5;
  localparam logic [2:0] MIDI_PITCH_BEND = 3'd6;

  localparam logic [7:0] MIDI_SYSEX_START = 8'hF0;
  localparam logic [7:0] MIDI_SYSEX_END   = 8'hF7;
  localparam logic [7:0] MIDI_RT_MIN      = 8'hF8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2,
    ST_SYSEX   = 2'd3
  } parse_state_t;

  function automatic logic [1:0] midi_data_len(input logic [2:0] msg_type);
    logic [1:0] len;
    case (msg_type)
      MIDI_PROG:    len = 2'd1;
      MIDI_CHAN_AT: len = 2'd1;
      3'd7:         len = 2'd0;
      default:      len = 2'd2;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream to channel-voice event parser with running status, SysEx
// skipping and real-time passthrough. Optional MIDI_CHANNEL_FILTER_EN adds omni.
module midi_msg_parser
  import midi_msg_parser_pkg::*;
#(
  parameter logic [3:0] DEFAULT_CHANNEL     = 4'd0,
  parameter bit         NOTE_ON_VEL0_AS_OFF = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
`ifdef MIDI_CHANNEL_FILTER_EN
  input  logic       omni,
`endif
  output logic       msg_valid,
  output logic [2:0] msg_type,
  output logic [3:0] msg_chan,
  output logic [6:0] msg_d1,
  output logic [6:0] msg_d2,
  output logic       rt_valid,
  output logic [7:0] rt_byte
);

  parse_state_t state, state_n;
  logic [2:0]   run_type, run_type_n;
  logic [3:0]   run_chan, run_chan_n;
  logic [6:0]   d1, d1_n;
  logic         emit;
  logic [6:0]   emit_d1;
  logic [6:0]   emit_d2;
  logic [2:0]   emit_type;
  logic         rt_fire;
  logic         chan_ok;

`ifdef MIDI_CHANNEL_FILTER_EN
  assign chan_ok = omni | (run_chan == DEFAULT_CHANNEL);
`else
  // Every channel passes; the compare keeps both builds on one parameter set
  assign chan_ok = 1'b1 | (run_chan == DEFAULT_CHANNEL);
`endif

  // Next-state decode of one received byte
  always_comb begin
    state_n    = state;
    run_type_n = run_type;
    run_chan_n = run_chan;
    d1_n       = d1;
    emit       = 1'b0;
    emit_d1    = d1;
    emit_d2    = 7'd0;
    rt_fire    = 1'b0;
    if (rx_valid) begin
      if (rx_byte >= MIDI_RT_MIN) begin
        rt_fire = 1'b1;
      end else if (rx_byte[7]) begin
        if (rx_byte < MIDI_SYSEX_START) begin
          run_type_n = rx_byte[6:4];
          run_chan_n = rx_byte[3:0];
          state_n    = ST_WAIT_D1;
        end else if (rx_byte == MIDI_SYSEX_START) begin
          run_type_n = 3'd0;
          run_chan_n = 4'd0;
          state_n    = ST_SYSEX;
        end else begin
          // System common or SysEx end: running status is lost
          run_type_n = 3'd0;
          run_chan_n = 4'd0;
          state_n    = ST_IDLE;
        end
      end else begin
        case (state)
          ST_WAIT_D1: begin
            d1_n = rx_byte[6:0];
            if (midi_data_len(run_type) == 2'd1) begin
              emit    = 1'b1;
              emit_d1 = rx_byte[6:0];
              emit_d2 = 7'd0;
            end else begin
              state_n = ST_WAIT_D2;
            end
          end
          ST_WAIT_D2: begin
            emit    = 1'b1;
            emit_d1 = d1;
            emit_d2 = rx_byte[6:0];
            state_n = ST_WAIT_D1;
          end
          default: begin
            state_n = state;
          end
        endcase
      end
    end else begin
      state_n = state;
    end
  end

  // Velocity-0 Note On folding into Note Off
  always_comb begin
    if (NOTE_ON_VEL0_AS_OFF && (run_type == MIDI_NOTE_ON) && (emit_d2 == 7'd0)) begin
      emit_type = MIDI_NOTE_OFF;
    end else begin
      emit_type = run_type;
    end
  end

  // Parser state and running status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      run_type <= 3'd0;
      run_chan <= 4'd0;
      d1       <= 7'd0;
    end else begin
      state    <= state_n;
      run_type <= run_type_n;
      run_chan <= run_chan_n;
      d1       <= d1_n;
    end
  end

  // Registered event outputs; fields hold until the next emitted message
  always_ff @(posedge clk) begin
    if (reset) begin
      msg_valid <= 1'b0;
      msg_type  <= 3'd0;
      msg_chan  <= 4'd0;
      msg_d1    <= 7'd0;
      msg_d2    <= 7'd0;
      rt_valid  <= 1'b0;
      rt_byte   <= 8'd0;
    end else begin
      msg_valid <= emit & chan_ok;
      if (emit && chan_ok) begin
        msg_type <= emit_type;
        msg_chan <= run_chan;
        msg_d1   <= emit_d1;
        msg_d2   <= emit_d2;
      end
      rt_valid <= rt_fire;
      if (rt_fire) begin
        rt_byte <= rx_byte;
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed self-checking bench for midi_msg_parser; covers the filter build
// when MIDI_CHANNEL_FILTER_EN is defined.
module tb_midi_msg_parser;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_byte;
`ifdef MIDI_CHANNEL_FILTER_EN
  logic       omni;
`endif
  logic       msg_valid;
  logic [2:0] msg_type;
  logic [3:0] msg_chan;
  logic [6:0] msg_d1;
  logic [6:0] msg_d2;
  logic       rt_valid;
  logic [7:0] rt_byte;

  int vectors     = 0;
  int miscompares = 0;
  int ev_cnt      = 0;
  int ev_base;

  always #5 clk = ~clk;

  midi_msg_parser dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
`ifdef MIDI_CHANNEL_FILTER_EN
    .omni      (omni),
`endif
    .msg_valid (msg_valid),
    .msg_type  (msg_type),
    .msg_chan  (msg_chan),
    .msg_d1    (msg_d1),
    .msg_d2    (msg_d2),
    .rt_valid  (rt_valid),
    .rt_byte   (rt_byte)
  );

  always @(posedge clk) begin
    if (msg_valid === 1'b1) ev_cnt <= ev_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one byte; returns on the negedge after the capturing posedge
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_msg(input string tag, input logic [2:0] t, input logic [3:0] c,
                           input logic [6:0] a, input logic [6:0] b);
    check({tag, ".valid"}, {31'd0, msg_valid}, 32'd1);
    check({tag, ".type"},  {29'd0, msg_type},  {29'd0, t});
    check({tag, ".chan"},  {28'd0, msg_chan},  {28'd0, c});
    check({tag, ".d1"},    {25'd0, msg_d1},    {25'd0, a});
    check({tag, ".d2"},    {25'd0, msg_d2},    {25'd0, b});
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".msg_valid"}, {31'd0, msg_valid}, 32'd0);
    check({tag, ".msg_type"},  {29'd0, msg_type},  32'd0);
    check({tag, ".msg_chan"},  {28'd0, msg_chan},  32'd0);
    check({tag, ".msg_d1"},    {25'd0, msg_d1},    32'd0);
    check({tag, ".msg_d2"},    {25'd0, msg_d2},    32'd0);
    check({tag, ".rt_valid"},  {31'd0, rt_valid},  32'd0);
    check({tag, ".rt_byte"},   {24'd0, rt_byte},   32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
`ifdef MIDI_CHANNEL_FILTER_EN
    omni     = 1'b1;
`endif
    idle(3);
    reset = 1'b0;
    check_zero("reset");

    // Plain Note On
    send(8'h90); send(8'h3C);
    check("noteon.early", {31'd0, msg_valid}, 32'd0);
    send(8'h64);
    check_msg("noteon", 3'd1, 4'd0, 7'h3C, 7'h64);
    idle(1);
    check("noteon.pulse", {31'd0, msg_valid}, 32'd0);
    check("noteon.hold", {25'd0, msg_d2}, 32'h64);

    // Running status with velocity-0 folding
    send(8'h91); send(8'h40); send(8'h7F);
    check_msg("rs1", 3'd1, 4'd1, 7'h40, 7'h7F);
    send(8'h41); send(8'h00);
    check_msg("rs2.vel0", 3'd0, 4'd1, 7'h41, 7'h00);

    // Real-time byte interleaved mid-message
    send(8'h90); send(8'h3C); send(8'hF8);
    check("rt.valid", {31'd0, rt_valid}, 32'd1);
    check("rt.byte", {24'd0, rt_byte}, 32'hF8);
    check("rt.nomsg", {31'd0, msg_valid}, 32'd0);
    send(8'h64);
    check("rt.pulse", {31'd0, rt_valid}, 32'd0);
    check_msg("rt.msg", 3'd1, 4'd0, 7'h3C, 7'h64);

    // SysEx terminated by channel status, then F7 and orphan data
    idle(2);
    ev_base = ev_cnt;
    send(8'hF0); send(8'h01); send(8'h02); send(8'h90);
    send(8'h03); send(8'hF7); send(8'h45);
    idle(2);
    check("sysex.events", ev_cnt - ev_base, 32'd0);

    // Program Change, 1-byte messages under running status
    send(8'hC2); send(8'h05);
    check_msg("prog1", 3'd4, 4'd2, 7'h05, 7'h00);
    send(8'h07);
    check_msg("prog2", 3'd4, 4'd2, 7'h07, 7'h00);

    // Channel aftertouch and pitch bend
    send(8'hD5); send(8'h7F);
    check_msg("chanat", 3'd5, 4'd5, 7'h7F, 7'h00);
    send(8'hE3); send(8'h00); send(8'h40);
    check_msg("bend", 3'd6, 4'd3, 7'h00, 7'h40);

    // Explicit Note Off keeps its nonzero velocity
    send(8'h8A); send(8'h30); send(8'h22);
    check_msg("noteoff", 3'd0, 4'hA, 7'h30, 7'h22);

    // New status in WAIT_D2 abandons; system common orphans data
    idle(2);
    ev_base = ev_cnt;
    send(8'h90); send(8'h3C); send(8'hB0); send(8'h07);
    send(8'hF1); send(8'h3C); send(8'h64);
    idle(2);
    check("abandon.events", ev_cnt - ev_base, 32'd0);

    // Reset mid-message discards the partial message
    send(8'hB0); send(8'h07);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check_zero("midreset");
    ev_base = ev_cnt;
    send(8'h64);
    idle(2);
    check("midreset.events", ev_cnt - ev_base, 32'd0);

`ifdef MIDI_CHANNEL_FILTER_EN
    omni = 1'b0;
    ev_base = ev_cnt;
    send(8'h93); send(8'h3C); send(8'h64);
    idle(2);
    check("filter.off", ev_cnt - ev_base, 32'd0);
    send(8'h90); send(8'h3C); send(8'h64);
    check_msg("filter.ch0", 3'd1, 4'd0, 7'h3C, 7'h64);
    omni = 1'b1;
    send(8'h93); send(8'h3C); send(8'h64);
    check_msg("filter.omni", 3'd1, 4'd3, 7'h3C, 7'h64);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
